// File: rtl/avl_arb_pkg.sv
// Shared types and helpers for the round-robin Avalon arbiter.
package avl_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } arbState_e;

   // Read data returned to a master whose transfer was aborted is all ones;
   // this is the fill bit replicated to the data width.
   localparam logic ABORT_RD_FILL = 1'b1;

   function automatic int unsigned rrNext(input int unsigned idx, input int unsigned num);
      return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/avl_rr_pick.sv
// Rotating priority encoder: first requester after last_i, wrapping modulo pNUM.
module avl_rr_pick
   import avl_arb_pkg::*;
#(
   parameter int pNUM       = 2,
   parameter int pIDX_WIDTH = $clog2(pNUM)
) (
   input  logic [pNUM-1:0]       req_i,
   input  logic [pIDX_WIDTH-1:0] last_i,
   output logic [pIDX_WIDTH-1:0] next_o,
   output logic                  found_o
);

   always_comb begin
      int unsigned idx;
      next_o  = last_i;
      found_o = 1'b0;
      idx     = rrNext(32'(last_i), pNUM);
      for (int k = 0; k < pNUM; k++) begin
         if (!found_o && req_i[idx[pIDX_WIDTH-1:0]]) begin
            found_o = 1'b1;
            next_o  = idx[pIDX_WIDTH-1:0];
         end
         idx = rrNext(idx, pNUM);
      end
   end

endmodule

// File: rtl/avl_arbiter_rr.sv
// Round-robin arbiter sharing one Avalon-style slave port among pNUM masters,
// with a one-cycle bubble between grants and an optional stall timeout.
module avl_arbiter_rr
   import avl_arb_pkg::*;
#(
   parameter int  pNUM        = 2,
   parameter int  pADDR_WIDTH = 8,
   parameter int  pDATA_WIDTH = 32,
   parameter int  pTIMEOUT    = 256,
   localparam int IW          = $clog2(pNUM)
) (
   input  logic                        avl_clock,
   input  logic                        avl_rst_n,
   input  logic [pNUM*pADDR_WIDTH-1:0] s_avl_addr,
   input  logic [pNUM-1:0]             s_avl_wrena,
   input  logic [pNUM*pDATA_WIDTH-1:0] s_avl_wrdata,
   input  logic [pNUM-1:0]             s_avl_rdena,
   output logic [pDATA_WIDTH-1:0]      s_avl_rddata,
   output logic [pNUM-1:0]             s_avl_wrq,
   output logic [pADDR_WIDTH-1:0]      m_avl_addr,
   output logic                        m_avl_wrena,
   output logic [pDATA_WIDTH-1:0]      m_avl_wrdata,
   output logic                        m_avl_rdena,
   input  logic [pDATA_WIDTH-1:0]      m_avl_rddata,
   input  logic                        m_avl_wrq,
   output logic [IW-1:0]               grant_idx,
   output logic                        grant_vld,
   output logic                        tmo_pulse
);

   localparam int            TW       = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((pTIMEOUT > 0) ? pTIMEOUT - 1 : 0);

   arbState_e                state_q, state_d;
   logic [IW-1:0]            grant_q, grant_d;
   logic [TW-1:0]            tmoCnt_q, tmoCnt_d;

   logic [pNUM-1:0]          req;
   logic [IW-1:0]            pickIdx;
   logic                     pickFound;
   logic                     selWr;
   logic                     selRd;
   logic                     selReq;
   logic [pADDR_WIDTH-1:0]   selAddr;
   logic [pDATA_WIDTH-1:0]   selData;
   logic                     timeoutHit;

   assign req        = s_avl_wrena | s_avl_rdena;
   assign selWr      = s_avl_wrena[grant_q];
   assign selRd      = s_avl_rdena[grant_q];
   assign selReq     = req[grant_q];
   assign selAddr    = s_avl_addr[grant_q*pADDR_WIDTH +: pADDR_WIDTH];
   assign selData    = s_avl_wrdata[grant_q*pDATA_WIDTH +: pDATA_WIDTH];
   assign timeoutHit = (pTIMEOUT != 0) && (tmoCnt_q == TMO_LAST) && m_avl_wrq;

   avl_rr_pick #(
      .pNUM       (pNUM),
      .pIDX_WIDTH (IW)
   ) u_pick (
      .req_i   (req),
      .last_i  (grant_q),
      .next_o  (pickIdx),
      .found_o (pickFound)
   );

   always_ff @(posedge avl_clock or negedge avl_rst_n) begin
      if (!avl_rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= IW'(pNUM - 1);
         tmoCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         tmoCnt_q <= tmoCnt_d;
      end
   end

   // A dropped request ends the grant silently; the counter only survives stalled BUSY cycles.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      tmoCnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (pickFound) begin
               grant_d = pickIdx;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!selReq || !m_avl_wrq) begin
               state_d = ST_IDLE;
            end else if (timeoutHit) begin
               state_d = ST_ABORT;
            end else begin
               tmoCnt_d = tmoCnt_q + 1'b1;
            end
         end
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m_avl_addr   = '0;
      m_avl_wrdata = '0;
      m_avl_wrena  = 1'b0;
      m_avl_rdena  = 1'b0;
      s_avl_wrq    = '1;
      s_avl_rddata = m_avl_rddata;
      grant_vld    = 1'b0;
      tmo_pulse    = 1'b0;
      case (state_q)
         ST_BUSY: begin
            m_avl_addr         = selAddr;
            m_avl_wrdata       = selData;
            m_avl_wrena        = selWr;
            m_avl_rdena        = selRd & ~selWr;
            s_avl_wrq[grant_q] = m_avl_wrq;
            grant_vld          = 1'b1;
         end
         ST_ABORT: begin
            s_avl_wrq[grant_q] = 1'b0;
            s_avl_rddata       = {pDATA_WIDTH{ABORT_RD_FILL}};
            tmo_pulse          = 1'b1;
         end
         default: ;
      endcase
   end

   assign grant_idx = grant_q;

endmodule

// File: tb/tb_avl_arbiter_rr.sv
// Self-checking bench for avl_arbiter_rr: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_avl_arbiter_rr;

   localparam int N   = 3;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int TMO = 8;
   localparam int IW  = $clog2(N);
   localparam int OW  = N + DW + AW + 1 + DW + 1 + IW + 1 + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*AW-1:0] sAddr;
   logic [N-1:0]    sWrena;
   logic [N*DW-1:0] sWrdata;
   logic [N-1:0]    sRdena;
   logic [DW-1:0]   sRddata;
   logic [N-1:0]    sWrq;
   logic [AW-1:0]   mAddr;
   logic            mWrena;
   logic [DW-1:0]   mWrdata;
   logic            mRdena;
   logic [DW-1:0]   mRddata;
   logic            mWrq;
   logic [IW-1:0]   grantIdx;
   logic            grantVld;
   logic            tmoPulse;

   int nChecks = 0;
   int nFails  = 0;

   // Reference model: owner phase (0 idle, 1 busy, 2 abort), granted master, stall count.
   int mState;
   int mGnt;
   int mStall;

   always #5 clk = ~clk;

   avl_arbiter_rr #(
      .pNUM        (N),
      .pADDR_WIDTH (AW),
      .pDATA_WIDTH (DW),
      .pTIMEOUT    (TMO)
   ) dut (
      .avl_clock    (clk),
      .avl_rst_n    (rst_n),
      .s_avl_addr   (sAddr),
      .s_avl_wrena  (sWrena),
      .s_avl_wrdata (sWrdata),
      .s_avl_rdena  (sRdena),
      .s_avl_rddata (sRddata),
      .s_avl_wrq    (sWrq),
      .m_avl_addr   (mAddr),
      .m_avl_wrena  (mWrena),
      .m_avl_wrdata (mWrdata),
      .m_avl_rdena  (mRdena),
      .m_avl_rddata (mRddata),
      .m_avl_wrq    (mWrq),
      .grant_idx    (grantIdx),
      .grant_vld    (grantVld),
      .tmo_pulse    (tmoPulse)
   );

   task automatic clearInputs();
      sAddr   = '0;
      sWrena  = '0;
      sWrdata = '0;
      sRdena  = '0;
      mWrq    = 1'b0;
      mRddata = '0;
   endtask

   task automatic setMaster(input int i, input logic wr, input logic rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      sWrena[i]          = wr;
      sRdena[i]          = rd;
      sAddr[i*AW +: AW]  = a;
      sWrdata[i*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      mState = 0;
      mGnt   = N - 1;
      mStall = 0;
   endtask

   task automatic doReset();
      clearInputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic modelExpect(output logic [OW-1:0] e);
      logic [N-1:0]  w;
      logic [DW-1:0] rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          we, re, gv, tp;
      w  = '1;
      rd = mRddata;
      a  = '0;
      d  = '0;
      we = 1'b0;
      re = 1'b0;
      gv = 1'b0;
      tp = 1'b0;
      if (mState == 1) begin
         a       = sAddr[mGnt*AW +: AW];
         d       = sWrdata[mGnt*DW +: DW];
         we      = sWrena[mGnt];
         re      = sRdena[mGnt] & ~sWrena[mGnt];
         w[mGnt] = mWrq;
         gv      = 1'b1;
      end else if (mState == 2) begin
         w[mGnt] = 1'b0;
         rd      = '1;
         tp      = 1'b1;
      end
      e = {w, rd, a, we, d, re, IW'(mGnt), gv, tp};
   endtask

   task automatic modelAdvance();
      logic [N-1:0] req;
      int           pick;
      req  = sWrena | sRdena;
      pick = -1;
      case (mState)
         0: begin
            for (int k = 1; k <= N; k++)
               if (pick < 0 && req[(mGnt + k) % N]) pick = (mGnt + k) % N;
            if (pick >= 0) begin
               mGnt   = pick;
               mState = 1;
               mStall = 0;
            end
         end
         1: begin
            if (!req[mGnt] || !mWrq) begin
               mState = 0;
               mStall = 0;
            end else if (mStall == TMO - 1) begin
               mState = 2;
               mStall = 0;
            end else begin
               mStall++;
            end
         end
         default: mState = 0;
      endcase
   endtask

   task automatic test_reset();
      logic [N+IW+AW+DW+4-1:0] got, exp;
      clearInputs();
      rst_n = 1'b0;
      setMaster(0, 1'b1, 1'b0, 8'h03, 32'h1);
      @(negedge clk);
      got = {grantVld, grantIdx, sWrq, mWrena, mRdena, mAddr, mWrdata, tmoPulse};
      exp = {1'b0, IW'(N - 1), {N{1'b1}}, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0};
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL reset_values: got %h expected %h", got, exp);
      end
      tick();
      rst_n = 1'b1;
      clearInputs();
      modelReset();
   endtask

   task automatic test_single_write();
      logic [1+1+AW+DW+N+IW+1-1:0] got, exp;
      doReset();
      setMaster(1, 1'b1, 1'b0, 8'h10, 32'hA5A5A5A5);
      mWrq = 1'b0;
      @(negedge clk);
      nChecks++;
      if ({mWrena, sWrq} !== {1'b0, 3'b111}) begin
         nFails++;
         $display("[TB] FAIL single_write_idle: got %b expected %b", {mWrena, sWrq}, {1'b0, 3'b111});
      end
      tick();
      @(negedge clk);
      got = {mWrena, mRdena, mAddr, mWrdata, sWrq, grantIdx, grantVld};
      exp = {1'b1, 1'b0, 8'h10, 32'hA5A5A5A5, 3'b101, 2'd1, 1'b1};
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL single_write_fwd: got %h expected %h", got, exp);
      end
      tick();
      clearInputs();
      @(negedge clk);
      nChecks++;
      if ({grantVld, mWrena, sWrq} !== {1'b0, 1'b0, 3'b111}) begin
         nFails++;
         $display("[TB] FAIL single_write_done: got %b expected %b", {grantVld, mWrena, sWrq}, {2'b00, 3'b111});
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0] ew;
      logic [IW-1:0] g;
      logic          busy;
      doReset();
      setMaster(0, 1'b0, 1'b1, 8'h01, 32'h0);
      setMaster(1, 1'b0, 1'b1, 8'h02, 32'h0);
      mWrq    = 1'b0;
      mRddata = 32'hCAFE0000;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         busy = (c % 2 == 1);
         g    = IW'(((c - 1) / 2) % 2);
         ew   = '1;
         if (busy) ew[g] = 1'b0;
         nChecks++;
         if (busy && ({grantVld, grantIdx, mRdena, sWrq} !== {1'b1, g, 1'b1, ew})) begin
            nFails++;
            $display("[TB] FAIL alternate_grant c=%0d: got %b expected %b", c,
                     {grantVld, grantIdx, mRdena, sWrq}, {1'b1, g, 1'b1, ew});
         end else if (!busy && ({grantVld, mRdena, sWrq} !== {1'b0, 1'b0, ew})) begin
            nFails++;
            $display("[TB] FAIL alternate_bubble c=%0d: got %b expected %b", c,
                     {grantVld, mRdena, sWrq}, {2'b00, ew});
         end
         tick();
      end
      clearInputs();
   endtask

   task automatic test_wait_states();
      doReset();
      setMaster(0, 1'b0, 1'b1, 8'h20, 32'h0);
      mWrq    = 1'b1;
      mRddata = 32'hDEADBEEF;
      @(negedge clk);
      tick();
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin
            mWrq    = 1'b0;
            mRddata = 32'h12345678;
         end
         @(negedge clk);
         nChecks++;
         if (c < 4 && ({sWrq, grantVld, mRdena, tmoPulse} !== {3'b111, 1'b1, 1'b1, 1'b0})) begin
            nFails++;
            $display("[TB] FAIL wait_stall c=%0d: got %b expected %b", c,
                     {sWrq, grantVld, mRdena, tmoPulse}, {3'b111, 3'b110});
         end else if (c == 4 && ({sWrq, sRddata, tmoPulse} !== {3'b110, 32'h12345678, 1'b0})) begin
            nFails++;
            $display("[TB] FAIL wait_done: got %h expected %h",
                     {sWrq, sRddata, tmoPulse}, {3'b110, 32'h12345678, 1'b0});
         end
         tick();
      end
      clearInputs();
   endtask

   task automatic test_timeout();
      doReset();
      setMaster(0, 1'b0, 1'b1, 8'h30, 32'h0);
      setMaster(1, 1'b1, 1'b0, 8'h31, 32'h0BADF00D);
      mWrq    = 1'b1;
      mRddata = 32'h0;
      @(negedge clk);
      tick();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         nChecks++;
         if ({grantVld, grantIdx, mRdena, tmoPulse, sWrq} !== {1'b1, 2'd0, 1'b1, 1'b0, 3'b111}) begin
            nFails++;
            $display("[TB] FAIL timeout_stall c=%0d: got %b expected %b", c,
                     {grantVld, grantIdx, mRdena, tmoPulse, sWrq}, {1'b1, 2'd0, 1'b1, 1'b0, 3'b111});
         end
         tick();
      end
      @(negedge clk);
      nChecks++;
      if ({tmoPulse, sRddata, sWrq, mWrena, mRdena, grantVld} !==
          {1'b1, 32'hFFFFFFFF, 3'b110, 1'b0, 1'b0, 1'b0}) begin
         nFails++;
         $display("[TB] FAIL timeout_abort: got %h expected %h",
                  {tmoPulse, sRddata, sWrq, mWrena, mRdena, grantVld},
                  {1'b1, 32'hFFFFFFFF, 3'b110, 3'b000});
      end
      tick();
      setMaster(0, 1'b0, 1'b0, 8'h0, 32'h0);
      mWrq = 1'b0;
      @(negedge clk);
      nChecks++;
      if ({grantVld, tmoPulse} !== 2'b00) begin
         nFails++;
         $display("[TB] FAIL timeout_bubble: got %b expected %b", {grantVld, tmoPulse}, 2'b00);
      end
      tick();
      @(negedge clk);
      nChecks++;
      if ({grantVld, grantIdx, mWrena, mAddr, sWrq} !== {1'b1, 2'd1, 1'b1, 8'h31, 3'b101}) begin
         nFails++;
         $display("[TB] FAIL timeout_next_grant: got %h expected %h",
                  {grantVld, grantIdx, mWrena, mAddr, sWrq}, {1'b1, 2'd1, 1'b1, 8'h31, 3'b101});
      end
      tick();
      clearInputs();
   endtask

   task automatic test_wr_precedence();
      doReset();
      setMaster(1, 1'b1, 1'b1, 8'h44, 32'h00000055);
      mWrq = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      nChecks++;
      if ({mWrena, mRdena, grantIdx, mWrdata} !== {1'b1, 1'b0, 2'd1, 32'h00000055}) begin
         nFails++;
         $display("[TB] FAIL wr_precedence: got %h expected %h",
                  {mWrena, mRdena, grantIdx, mWrdata}, {1'b1, 1'b0, 2'd1, 32'h00000055});
      end
      tick();
      clearInputs();
   endtask

   task automatic test_reset_mid_busy();
      doReset();
      setMaster(1, 1'b1, 1'b0, 8'h66, 32'h77);
      mWrq = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      nChecks++;
      if ({grantVld, grantIdx} !== {1'b1, 2'd1}) begin
         nFails++;
         $display("[TB] FAIL midrst_busy: got %b expected %b", {grantVld, grantIdx}, {1'b1, 2'd1});
      end
      #2;
      rst_n = 1'b0;
      #1;
      nChecks++;
      if ({grantVld, grantIdx, sWrq, mWrena, mAddr, mWrdata} !==
          {1'b0, IW'(N - 1), 3'b111, 1'b0, 8'h00, 32'h0}) begin
         nFails++;
         $display("[TB] FAIL midrst_async: got %h expected %h",
                  {grantVld, grantIdx, sWrq, mWrena, mAddr, mWrdata},
                  {1'b0, IW'(N - 1), 3'b111, 1'b0, 8'h00, 32'h0});
      end
      tick();
      rst_n = 1'b1;
      modelReset();
      setMaster(0, 1'b0, 1'b1, 8'h01, 32'h0);
      mWrq = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      nChecks++;
      if ({grantVld, grantIdx} !== {1'b1, 2'd0}) begin
         nFails++;
         $display("[TB] FAIL midrst_priority: got %b expected %b", {grantVld, grantIdx}, {1'b1, 2'd0});
      end
      tick();
      clearInputs();
   endtask

   task automatic test_random();
      logic [OW-1:0] got, exp;
      logic [N-1:0]  req, done;
      int            stuckLeft;
      int            op;
      stuckLeft = 0;
      doReset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         modelExpect(exp);
         got = {sWrq, sRddata, mAddr, mWrena, mWrdata, mRdena, grantIdx, grantVld, tmoPulse};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL random c=%0d: got %h expected %h", c, got, exp);
         end
         req  = sWrena | sRdena;
         done = req & ~exp[OW-1 -: N];
         modelAdvance();
         tick();
         for (int i = 0; i < N; i++) begin
            if (done[i] || !req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  op = $urandom_range(0, 2);
                  setMaster(i, op != 1, op != 0, AW'($urandom), $urandom);
               end else begin
                  setMaster(i, 1'b0, 1'b0, AW'($urandom), $urandom);
               end
            end else if ($urandom_range(0, 39) == 0) begin
               setMaster(i, 1'b0, 1'b0, AW'($urandom), $urandom);
            end
         end
         if (stuckLeft > 0) begin
            mWrq = 1'b1;
            stuckLeft--;
         end else if ($urandom_range(0, 49) == 0) begin
            mWrq      = 1'b1;
            stuckLeft = 12;
         end else begin
            mWrq = ($urandom_range(0, 99) < 35);
         end
         mRddata = $urandom;
      end
      clearInputs();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      clearInputs();
      modelReset();
      test_reset();
      test_single_write();
      test_alternate();
      test_wait_states();
      test_timeout();
      test_wr_precedence();
      test_reset_mid_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
